softex_fp_lane_packer: RTL
==========================

// Module: softex_fp_lane_packer
// PURPOSE
// - Scalar-to-vector packer; the inverse direction of the FP adder reduction tree.
// - Accepts one FP scalar per handshake (e.g. reduced sums, reciprocals).
// - Packs the scalars into an N_OUT-lane vector with a per-lane strobe, for the lane-parallel datapath downstream.
// - Emits a vector when all lanes are filled, or early when the last input element is accepted.
// PARAMETERS
// - FPFORMAT  FPFORMAT_ACC  fpnew_pkg::fp_format_e of the scalars; localparam WIDTH = fp_width(FPFORMAT)
// - N_OUT     4             number of output lanes, >= 1
// - TAG_TYPE  logic         sideband tag type; travels with the vector
// - localparam CNT_W = max(1, $clog2(N_OUT))
// PORTS
// - clk_i    in   1                 clock; single clock domain
// - rst_i    in   1                 asynchronous, active-high reset
// - clear_i  in   1                 synchronous clear; drops partial and pending vectors
// - valid_i  in   1                 input scalar valid
// - ready_o  out  1                 input scalar ready
// - data_i   in   WIDTH             input scalar
// - strb_i   in   1                 input scalar strobe; copied to the lane strobe
// - last_i   in   1                 scalar closes the current vector
// - tag_i    in   TAG_TYPE          tag; sampled with the lane-0 element only
// - valid_o  out  1                 output vector valid
// - ready_i  in   1                 output vector ready
// - data_o   out  N_OUT x WIDTH     packed lanes; lane k is the k-th accepted scalar
// - strb_o   out  N_OUT             lane strobes
// - tag_o    out  TAG_TYPE          tag of the vector
// - busy_o   out  1                 partial vector held, or output pending
// BEHAVIOUR
// - Reset values: state=FILL, cnt=0, data_o='0, strb_o='0, tag_o='0, valid_o=0, busy_o=0.
// - ready_o is held 0 while rst_i is asserted.
// - FSM FILL (valid_o=0): ready_o=1.
//   - Input handshake (valid_i & ready_o): lane[cnt]<=data_i, strb[cnt]<=strb_i.
//   - If cnt==0, all other lanes are also cleared (strb=0) and tag<=tag_i.
//   - If cnt==N_OUT-1 or last_i: go to DRAIN and cnt<=0. Otherwise cnt<=cnt+1.
// - FSM DRAIN (valid_o=1): ready_o=ready_i.
//   - Output handshake without an input handshake: go to FILL.
//   - Simultaneous output and input handshake: the new scalar is written to lane 0 of a fresh vector (other lanes cleared, new tag).
//     - Stay in DRAIN if that scalar has last_i or N_OUT==1; else go to FILL with cnt=1.
// - Latency: valid_o rises the cycle after the closing input handshake.
// - Throughput: one scalar per cycle, with no bubble on vector turnover.
// - data_o, strb_o and tag_o are stable while valid_o & !ready_i (AXI-style hold).
// - Lanes beyond the last accepted element have strb_o=0.
// - last_i at cnt==0 gives a 1-lane vector.
// - last_i at cnt==N_OUT-1 gives exactly one vector, never an extra empty one.
// - N_OUT==1: every accepted scalar is emitted as a 1-lane vector; last_i is ignored.
// - clear_i has priority over both handshakes in the same cycle.
//   - Effect: state=FILL, cnt=0, strb_o='0, valid_o=0. The clearing cycle accepts no input.
// - Asserting rst_i mid-vector returns everything to reset values immediately.
// - busy_o = (state==DRAIN) | (cnt!=0).
// CONFIGURATION
// - `SOFTEX_PACKER_ZERO_MASK_EN defined: data_o[k] is forced to '0 (+0.0) whenever strb_o[k]==0.
//   - Result: masked lanes are numerically neutral for the downstream adder tree.
// - Not defined: masked lanes carry stale register contents (don't care). No extra muxes.
// TESTING
// - N_OUT=4: 8 back-to-back scalars 1.0..8.0, strb=1, ready_i=1
//   -> two vectors {1,2,3,4} then {5,6,7,8}, strb_o=4'hF, no input stall.
// - 3 scalars, the third with last_i=1
//   -> one vector, strb_o=4'b0111, lane3 strb=0 (data 0 with ZERO_MASK_EN).
// - Full vector pending, ready_i=0 for 5 cycles
//   -> ready_o=0, data_o/tag_o stable; then ready_i=1 with valid_i=1 -> next scalar lands in lane 0 in the same cycle.
// - clear_i after 2 of 4 scalars, then 4 new scalars
//   -> only the new vector emitted, tag = tag of the first new scalar.
// - N_OUT=1, scalars A, B with ready_i toggling each cycle
//   -> outputs A, B in order, each strb_o=1, no loss or duplication.
// - rst_i asserted while in DRAIN
//   -> valid_o=0, busy_o=0, strb_o=0 in the same cycle; the next accepted scalar starts at lane 0.

Source files
------------

// File: rtl/softex_fp_lane_packer_if.sv
// Handshake bundle for softex_fp_lane_packer: scalar input stream, packed vector
// output stream, synchronous clear and busy status. Signal names follow the packer's view.
interface softex_fp_lane_packer_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_OUT    = 4,
    parameter type         TAG_TYPE = logic
);
    logic                             clear_i;
    logic                             valid_i;
    logic                             ready_o;
    logic [WIDTH-1:0]                 data_i;
    logic                             strb_i;
    logic                             last_i;
    TAG_TYPE                          tag_i;
    logic                             valid_o;
    logic                             ready_i;
    logic [N_OUT-1:0][WIDTH-1:0]      data_o;
    logic [N_OUT-1:0]                 strb_o;
    TAG_TYPE                          tag_o;
    logic                             busy_o;

    modport slave (
        input  clear_i, valid_i, data_i, strb_i, last_i, tag_i, ready_i,
        output ready_o, valid_o, data_o, strb_o, tag_o, busy_o
    );

    modport master (
        output clear_i, valid_i, data_i, strb_i, last_i, tag_i, ready_i,
        input  ready_o, valid_o, data_o, strb_o, tag_o, busy_o
    );
endinterface

// File: rtl/softex_fp_lane_packer.sv
// Scalar-to-vector packer: gathers FP scalars into an N_OUT-lane vector with lane strobes.
// Optional `SOFTEX_PACKER_ZERO_MASK_EN forces unstrobed lanes of data_o to +0.0.
module softex_fp_lane_packer #(
    parameter int unsigned FPFORMAT = 0,        // fpnew fp_format_e encoding, 0 = FP32 (accumulator format)
    parameter int unsigned N_OUT    = 4,
    parameter type         TAG_TYPE = logic
) (
    input logic                    clk_i,
    input logic                    rst_i,
    softex_fp_lane_packer_if.slave bus
);

    function automatic int unsigned fp_width(input int unsigned fmt);
        case (fmt)
            0:       return 32;  // FP32
            1:       return 64;  // FP64
            2:       return 16;  // FP16
            3:       return 8;   // FP8
            4:       return 16;  // FP16ALT
            default: return 32;
        endcase
    endfunction

    localparam int unsigned WIDTH = fp_width(FPFORMAT);
    localparam int unsigned CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [N_OUT-1:0][WIDTH-1:0] lane_q, lane_d;
    logic [N_OUT-1:0]            strb_q, strb_d;
    TAG_TYPE                     tag_q, tag_d;

    logic in_hs, out_hs, cnt_last;

    assign bus.valid_o = (state_q == DRAIN);
    // Clear wins over both handshakes, so the clearing cycle must not advertise ready.
    assign bus.ready_o = !rst_i && !bus.clear_i && ((state_q == FILL) || bus.ready_i);
    assign in_hs       = bus.valid_i && bus.ready_o;
    assign out_hs      = bus.valid_o && bus.ready_i;
    assign cnt_last    = (cnt_q == CNT_W'(N_OUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        strb_d  = strb_q;
        tag_d   = tag_q;
        if (bus.clear_i) begin
            state_d = FILL;
            cnt_d   = '0;
            strb_d  = '0;
        end else if (state_q == FILL) begin
            if (in_hs) begin
                if (cnt_q == '0) begin
                    strb_d = '0;
                    tag_d  = bus.tag_i;
                end
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        lane_d[k] = bus.data_i;
                        strb_d[k] = bus.strb_i;
                    end
                end
                if (cnt_last || bus.last_i) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (out_hs) begin
            if (in_hs) begin
                // Turnover without a bubble: the incoming scalar opens a fresh vector in lane 0.
                strb_d    = '0;
                strb_d[0] = bus.strb_i;
                lane_d[0] = bus.data_i;
                tag_d     = bus.tag_i;
                if (bus.last_i || (N_OUT == 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    state_d = FILL;
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            lane_q  <= '0;
            strb_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            strb_q  <= strb_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.strb_o = strb_q;
    assign bus.tag_o  = tag_q;
    assign bus.busy_o = (state_q == DRAIN) || (cnt_q != '0);

`ifdef SOFTEX_PACKER_ZERO_MASK_EN
    always_comb begin
        bus.data_o = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            bus.data_o[k] = strb_q[k] ? lane_q[k] : '0;
        end
    end
`else
    assign bus.data_o = lane_q;
`endif

endmodule
